combo_code_entry: RTL and testbench
===================================

# combo_code_entry

Upstream input stage for the combination lock. Synchronises the four raw code switches, debounces them as a 4-bit vector, and converts each clean press (released → non-zero) into one registered code word with a one-cycle strobe. The lock consumes `code`/`code_valid` instead of raw pins, so bounce never registers as multiple digits.

## Interface
- `DEBOUNCE_CYCLES`, default 8: consecutive identical synchronised samples needed to qualify a value; legal range 2..255; counter width is `$clog2(DEBOUNCE_CYCLES+1)`.
- `CLK`  input  1  single clock, all state on rising edge.
- `RST`  input  1  synchronous, active-low reset; sampled on `CLK` only.
- `raw_code`  input  4  asynchronous switch lines, 1 = pressed.
- `enable`  input  1  synchronous; when 0, qualified presses emit no strobe.
- `code`  output  4  last accepted code word, registered.
- `code_valid`  output  1  one-cycle strobe, high in the cycle `code` is first updated.
- `code_held`  output  1  high while the accepted press is still held, registered.

## Operation
- Sync: two flops `sync1 ← raw_code`, `sync2 ← sync1`; no other logic reads `raw_code`.
- Debounce core, every cycle:
  - `sync2 != cand`: `cand ← sync2`, `cnt ← 0`.
  - Otherwise, if `cnt < DEBOUNCE_CYCLES`: `cnt ← cnt+1`; saturates at `DEBOUNCE_CYCLES`.
- `qual` (combinational) = `sync2 == cand && cnt == DEBOUNCE_CYCLES-1`.
  - Exactly one cycle per stable run; no repeat while the value stays put.
- FSM, states `WAIT_RELEASE`, `WAIT_PRESS`, `HELD`:
  - `WAIT_RELEASE`: `qual && cand == 0` → `WAIT_PRESS`.
  - `WAIT_PRESS`: `qual && cand != 0 && enable` → `HELD`; `code ← cand`; `code_valid` = 1 next cycle.
  - `WAIT_PRESS`: `qual && cand != 0 && !enable` → `WAIT_RELEASE`; no strobe; `code` unchanged.
  - `HELD`: `qual && cand == 0` → `WAIT_PRESS`. Qualified non-zero changes while held (e.g. 0001→0011) are ignored; no strobe.
- `code_held` = (state == `HELD`).
- Reset values:
  - `sync1`, `sync2`, `cand`, `cnt` = 0.
  - State = `WAIT_RELEASE`.
  - `code` = 0, `code_valid` = 0, `code_held` = 0.
- Reset-state rule: a key held through reset never strobes. A qualified zero is required first.
- Reset mid-operation: takes effect on the next edge regardless of state. An in-flight strobe is suppressed, and `code` returns to 0.
- `enable` is sampled only in the `qual` cycle. Toggling it at other times has no effect.

## Timing
- Raw value first captured by `sync1` at edge E0.
  - `cand` updates at E2.
  - `qual` is high during the cycle after E(DEBOUNCE_CYCLES+1).
  - `code`/`code_valid`/`code_held` update at E(DEBOUNCE_CYCLES+2).
  - Press-to-strobe latency is therefore DEBOUNCE_CYCLES+3 edges; 11 at default.
- Release-to-`WAIT_PRESS` latency is the same: DEBOUNCE_CYCLES+3 edges.
- Any glitch shorter than DEBOUNCE_CYCLES samples after `sync2` restarts `cnt` and produces no `qual`.
- Minimum press-to-press spacing: 2×(DEBOUNCE_CYCLES+3) edges, covering press plus release.
- `code_valid` is never high on two consecutive cycles.

## Structure
- Shared package `combo_pkg`:
  - `entry_state_t` enum (`WAIT_RELEASE`=2'd0, `WAIT_PRESS`=2'd1, `HELD`=2'd2).
  - `CODE_W` = 4.
  - `DEFAULT_DEBOUNCE` = 8.
- One sub-module, `combo_debounce_core`: synchroniser, `cand`, `cnt`, `qual`; parameterised on `DEBOUNCE_CYCLES` and `CODE_W`.
- The FSM and output registers stay in `combo_code_entry`.
- Expected RTL: roughly 150–200 lines.

## Test plan
- Reset with `raw_code`=0, then hold 4'b0101 for 20 cycles with `enable`=1 → exactly one `code_valid` 11 edges after first sample; `code`=4'b0101; `code_held`=1 until 11 edges after release.
- Bounce: 4'b0011 toggling every 3 cycles for 30 cycles, then steady → no strobe during the bounce; one strobe with `code`=4'b0011 11 edges after the last toggle.
- Key 4'b1000 held through reset deassertion → no strobe ever. After release, then a press of 4'b0001 → strobe, `code`=4'b0001.
- Press 4'b0010 and qualify, then change to 4'b0110 while held → one strobe only; `code` stays 4'b0010.
- `enable`=0 during a qualified press of 4'b1111 → no strobe, `code` remains previous value. After release with `enable`=1, a press of 4'b0100 strobes.
- Assert `RST`=0 on the cycle before an expected strobe → `code_valid` stays 0; `code`=0; state `WAIT_RELEASE`; key must be released before the next accept.

Source files
------------

// File: rtl/combo_pkg.sv
// Shared types and constants for the combination-lock code entry front end.
package combo_pkg;

  typedef enum logic [1:0] {
    WAIT_RELEASE = 2'd0,
    WAIT_PRESS   = 2'd1,
    HELD         = 2'd2
  } entry_state_t;

  localparam int CODE_W           = 4;
  localparam int DEFAULT_DEBOUNCE = 8;

endpackage

// File: rtl/combo_debounce_core.sv
// Two-flop synchroniser plus vector debouncer; qual pulses once per stable run.
module combo_debounce_core #(
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int CODE_W          = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CODE_W-1:0] raw_code,
  output logic [CODE_W-1:0] cand,
  output logic              qual
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_QUAL = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CODE_W-1:0] sync1;
  logic [CODE_W-1:0] sync2;
  logic [CNT_W-1:0]  cnt;

  // Count saturates one past the qualify point so qual cannot repeat.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1 <= '0;
      sync2 <= '0;
      cand  <= '0;
      cnt   <= '0;
    end else begin
      sync1 <= raw_code;
      sync2 <= sync1;
      if (sync2 != cand) begin
        cand <= sync2;
        cnt  <= '0;
      end else if (cnt < CNT_MAX) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign qual = (sync2 == cand) && (cnt == CNT_QUAL);

endmodule

// File: rtl/combo_code_entry.sv
// Code entry stage: debounced switches become one registered code word per press.
module combo_code_entry
  import combo_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [CODE_W-1:0] raw_code,
  input  logic              enable,
  output logic [CODE_W-1:0] code,
  output logic              code_valid,
  output logic              code_held
);

  entry_state_t      state;
  entry_state_t      next_state;
  logic [CODE_W-1:0] cand;
  logic              qual;
  logic [CODE_W-1:0] next_code;
  logic              next_valid;

  combo_debounce_core #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CODE_W         (CODE_W)
  ) u_core (
    .clk     (CLK),
    .rst     (RST),
    .raw_code(raw_code),
    .cand    (cand),
    .qual    (qual)
  );

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state      <= WAIT_RELEASE;
      code       <= '0;
      code_valid <= 1'b0;
    end else begin
      state      <= next_state;
      code       <= next_code;
      code_valid <= next_valid;
    end
  end

  // A press only counts after a qualified all-released value has been seen.
  always_comb begin
    next_state = state;
    next_code  = code;
    next_valid = 1'b0;
    case (state)
      WAIT_RELEASE: begin
        if (qual && cand == '0) next_state = WAIT_PRESS;
      end
      WAIT_PRESS: begin
        if (qual && cand != '0) begin
          if (enable) begin
            next_state = HELD;
            next_code  = cand;
            next_valid = 1'b1;
          end else begin
            next_state = WAIT_RELEASE;
          end
        end
      end
      HELD: begin
        if (qual && cand == '0) next_state = WAIT_PRESS;
      end
      default: next_state = WAIT_RELEASE;
    endcase
  end

  assign code_held = (state == HELD);

endmodule

// File: tb/tb_combo_code_entry.sv
// Bench for combo_code_entry: scoreboarded strobes, vector table, corner sequences.
module tb_combo_code_entry;

  localparam int LAT     = 11;
  localparam int RELEASE = 2 * LAT;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [3:0] raw_code = 4'b0000;
  logic       enable = 1'b1;
  logic [3:0] code;
  logic       code_valid;
  logic       code_held;

  int cyc = 0;
  int checks = 0;
  int passes = 0;
  logic prev_valid = 1'b0;

  typedef struct {
    logic [3:0] code;
    int         cyc;
  } sb_item_t;

  typedef struct {
    logic [3:0] press;
    logic       en;
    logic       strobe;
    logic [3:0] exp_code;
  } vec_t;

  sb_item_t sb_q[$];
  vec_t     vecs[5];

  combo_code_entry dut (
    .CLK       (CLK),
    .RST       (RST),
    .raw_code  (raw_code),
    .enable    (enable),
    .code      (code),
    .code_valid(code_valid),
    .code_held (code_held)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual == expected) passes++;
    else $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic press(input logic [3:0] value, input logic expect_strobe);
    raw_code = value;
    if (expect_strobe) sb_q.push_back('{code: value, cyc: cyc + LAT});
  endtask

  task automatic releaseKeys(input int n);
    raw_code = 4'b0000;
    step(n);
  endtask

  task automatic applyStimulus(input vec_t v);
    releaseKeys(RELEASE);
    enable = v.en;
    press(v.press, v.strobe);
    step(LAT + 3);
    checkOutput("vec_code", code, v.exp_code);
    checkOutput("vec_held", code_held, v.strobe);
  endtask

  // Every strobe must match the oldest queued expectation in value and cycle.
  always @(negedge CLK) begin
    if (code_valid) begin
      if (sb_q.size() == 0) begin
        checkOutput("unexpected_strobe", 1, 0);
      end else begin
        sb_item_t e;
        e = sb_q.pop_front();
        checkOutput("strobe_code", code, e.code);
        checkOutput("strobe_cycle", cyc, e.cyc);
      end
      checkOutput("valid_back_to_back", prev_valid, 0);
    end
    prev_valid = code_valid;
  end

  initial begin
    vecs[0] = '{press: 4'b1111, en: 1'b0, strobe: 1'b0, exp_code: 4'b0010};
    vecs[1] = '{press: 4'b0100, en: 1'b1, strobe: 1'b1, exp_code: 4'b0100};
    vecs[2] = '{press: 4'b1001, en: 1'b1, strobe: 1'b1, exp_code: 4'b1001};
    vecs[3] = '{press: 4'b0111, en: 1'b0, strobe: 1'b0, exp_code: 4'b1001};
    vecs[4] = '{press: 4'b1110, en: 1'b1, strobe: 1'b1, exp_code: 4'b1110};

    // Reset state
    step(5);
    checkOutput("reset_code", code, 0);
    checkOutput("reset_valid", code_valid, 0);
    checkOutput("reset_held", code_held, 0);
    RST = 1'b1;
    step(20);

    // Basic press and release timing
    press(4'b0101, 1'b1);
    step(20);
    checkOutput("basic_code", code, 4'b0101);
    checkOutput("basic_held", code_held, 1);
    raw_code = 4'b0000;
    step(LAT - 1);
    checkOutput("release_held_before", code_held, 1);
    step(1);
    checkOutput("release_held_after", code_held, 0);
    step(LAT);

    // Bounce: 3-cycle segments never qualify; strobe follows the last edge
    for (int i = 0; i <= 10; i++) begin
      if (i == 10) press(4'b0011, 1'b1);
      else raw_code = (i % 2 == 0) ? 4'b0011 : 4'b0000;
      step(3);
    end
    step(LAT + 3);
    checkOutput("bounce_code", code, 4'b0011);

    // Key held through reset never strobes
    RST = 1'b0;
    raw_code = 4'b1000;
    step(4);
    RST = 1'b1;
    step(30);
    checkOutput("held_reset_code", code, 0);
    checkOutput("held_reset_held", code_held, 0);
    releaseKeys(RELEASE);
    press(4'b0001, 1'b1);
    step(LAT + 3);
    checkOutput("after_held_code", code, 4'b0001);

    // Change while held is ignored
    releaseKeys(RELEASE);
    press(4'b0010, 1'b1);
    step(LAT + 3);
    raw_code = 4'b0110;
    step(25);
    checkOutput("change_held_code", code, 4'b0010);
    checkOutput("change_held_held", code_held, 1);

    // Vector table (enable gating included)
    for (int i = 0; i < 5; i++) applyStimulus(vecs[i]);
    enable = 1'b1;

    // Reset on the cycle before a strobe
    releaseKeys(RELEASE);
    press(4'b0110, 1'b0);
    step(LAT - 1);
    RST = 1'b0;
    step(1);
    checkOutput("midreset_valid", code_valid, 0);
    checkOutput("midreset_code", code, 0);
    checkOutput("midreset_held", code_held, 0);
    RST = 1'b1;
    step(30);
    checkOutput("midreset_still_code", code, 0);
    releaseKeys(RELEASE);
    press(4'b0001, 1'b1);
    step(LAT + 3);
    checkOutput("midreset_next_code", code, 4'b0001);
    releaseKeys(RELEASE);

    checkOutput("pending_strobes", sb_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
